// File: rtl/adc_capture_ctrl_if.sv
// AXI-Stream master/slave bundle carrying captured samples to the DMA input.
interface adc_capture_ctrl_if #(
    parameter int unsigned DATA_W = 16
) ();
    logic [DATA_W-1:0] TDATA;
    logic              TVALID;
    logic              TREADY;
    logic              TLAST;

    modport master (output TDATA, output TVALID, output TLAST, input TREADY);
    modport slave  (input TDATA, input TVALID, input TLAST, output TREADY);
endinterface

// File: rtl/adc_capture_ctrl.sv
// Capture sequencer: collects dsize samples (ADC or test counter) into a
// FWFT FIFO and streams them out as one TLAST-terminated packet.
module adc_capture_ctrl #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned FIFO_AW = 4
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic                      cr_start,
    input  logic                      cr_test,
    input  logic [31:0]               dsize,
    input  logic [DATA_W-1:0]         adc_data,
    input  logic                      adc_valid,
    adc_capture_ctrl_if.master        m_axis,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow
);
    localparam int unsigned DEPTH   = 1 << FIFO_AW;
    localparam int unsigned PTR_W   = FIFO_AW + 1;
    localparam int unsigned ENTRY_W = DATA_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         len_q, len_d;
    logic                test_q, test_d;
    logic [31:0]         cnt_q, cnt_d;
    logic [DATA_W-1:0]   pat_q, pat_d;
    logic                ovf_q, ovf_d;
    logic                done_q, done_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [ENTRY_W-1:0]  mem [DEPTH];

    logic                full_c;
    logic                empty_c;
    logic                push_c;
    logic                pop_c;
    logic                last_c;
    logic [DATA_W-1:0]   push_data_c;
    logic [ENTRY_W-1:0]  head_c;

    // FIFO status derived from the registered pointers only
    assign empty_c     = (wr_ptr_q == rd_ptr_q);
    assign full_c      = ((wr_ptr_q - rd_ptr_q) == PTR_W'(DEPTH));
    assign head_c      = mem[rd_ptr_q[FIFO_AW-1:0]];
    assign pop_c       = !empty_c && m_axis.TREADY;
    assign last_c      = (cnt_q == (len_q - 32'd1));
    assign push_data_c = test_q ? pat_q : adc_data;

    // State register
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state, push decision and datapath updates
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        test_d   = test_q;
        cnt_d    = cnt_q;
        pat_d    = pat_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        push_c   = 1'b0;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;

        case (state_q)
            IDLE: begin
                if (cr_start && (dsize != 32'd0)) begin
                    state_d = CAPTURE;
                    len_d   = dsize;
                    test_d  = cr_test;
                    cnt_d   = 32'd0;
                    pat_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            CAPTURE: begin
                if (!full_c && (test_q || adc_valid)) begin
                    push_c = 1'b1;
                    cnt_d  = cnt_q + 32'd1;
                    pat_d  = pat_q + DATA_W'(1);
                    if (last_c) state_d = DRAIN;
                end
                if (!test_q && adc_valid && full_c) ovf_d = 1'b1;
            end
            DRAIN: begin
                if (pop_c && head_c[DATA_W]) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // Datapath and FIFO pointer registers
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            len_q    <= 32'd0;
            test_q   <= 1'b0;
            cnt_q    <= 32'd0;
            pat_q    <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            len_q    <= len_d;
            test_q   <= test_d;
            cnt_q    <= cnt_d;
            pat_q    <= pat_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty
    always_ff @(posedge ACLK) begin
        if (push_c) mem[wr_ptr_q[FIFO_AW-1:0]] <= {last_c, push_data_c};
    end

    // Head entry drives the stream; data forced to zero when nothing is queued
    assign m_axis.TVALID = !empty_c;
    assign m_axis.TDATA  = empty_c ? '0 : head_c[DATA_W-1:0];
    assign m_axis.TLAST  = !empty_c && head_c[DATA_W];
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign overflow      = ovf_q;
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Scoreboard bench for adc_capture_ctrl: stimulus queues expected beats,
// a negedge monitor pops and compares every stream handshake.
module tb_adc_capture_ctrl;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned FIFO_AW = 4;

    logic              ACLK;
    logic              ARESETN;
    logic              cr_start;
    logic              cr_test;
    logic [31:0]       dsize;
    logic [DATA_W-1:0] adc_data;
    logic              adc_valid;
    logic              busy;
    logic              done;
    logic              overflow;

    adc_capture_ctrl_if #(.DATA_W(DATA_W)) axis ();

    adc_capture_ctrl #(.DATA_W(DATA_W), .FIFO_AW(FIFO_AW)) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .cr_start  (cr_start),
        .cr_test   (cr_test),
        .dsize     (dsize),
        .adc_data  (adc_data),
        .adc_valid (adc_valid),
        .m_axis    (axis),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int tests  = 0;
    int failed = 0;
    int beats  = 0;
    int pkts   = 0;

    logic [DATA_W:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic start(input logic [31:0] n, input logic t);
        cr_start = 1'b1;
        dsize    = n;
        cr_test  = t;
        tick();
        cr_start = 1'b0;
    endtask

    task automatic push_pattern(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), DATA_W'(i)});
    endtask

    task automatic wait_pkts(input int target, input int budget);
        int c;
        c = 0;
        while (pkts < target && c < budget) begin
            tick();
            c++;
        end
        if (pkts < target) check("pkt_timeout", 32'(pkts), 32'(target));
    endtask

    // Monitor: stream scoreboard, AXIS stability and done timing
    logic              hold_v;
    logic [DATA_W-1:0] hold_d;
    logic              hold_l;
    logic              last_hs;
    logic [DATA_W:0]   e;

    always @(negedge ACLK) begin
        if (!ARESETN) begin
            hold_v  = 1'b0;
            last_hs = 1'b0;
        end else begin
            check("done", 32'(done), 32'(last_hs));
            if (hold_v) begin
                check("hold_valid", 32'(axis.TVALID), 32'd1);
                check("hold_data", 32'(axis.TDATA), 32'(hold_d));
                check("hold_last", 32'(axis.TLAST), 32'(hold_l));
            end
            if (axis.TVALID && axis.TREADY) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'(axis.TDATA), 32'hDEAD_BEEF);
                end else begin
                    e = exp_q.pop_front();
                    check("tdata", 32'(axis.TDATA), 32'(e[DATA_W-1:0]));
                    check("tlast", 32'(axis.TLAST), 32'(e[DATA_W]));
                end
                beats++;
                if (axis.TLAST) pkts++;
            end
            hold_v  = axis.TVALID && !axis.TREADY;
            hold_d  = axis.TDATA;
            hold_l  = axis.TLAST;
            last_hs = axis.TVALID && axis.TREADY && axis.TLAST;
        end
    end

    initial begin
        int busy_cycles;
        int b0;
        int p0;
        int c;

        hold_v      = 1'b0;
        last_hs     = 1'b0;
        ARESETN     = 1'b0;
        cr_start    = 1'b0;
        cr_test     = 1'b0;
        dsize       = 32'd0;
        adc_data    = '0;
        adc_valid   = 1'b0;
        axis.TREADY = 1'b1;
        tick();
        tick();
        check("rst_tvalid", 32'(axis.TVALID), 32'd0);
        check("rst_tdata", 32'(axis.TDATA), 32'd0);
        check("rst_tlast", 32'(axis.TLAST), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        ARESETN = 1'b1;
        tick();

        // Test mode, 8 beats, busy for exactly dsize+1 cycles
        push_pattern(8);
        start(32'd8, 1'b1);
        busy_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) busy_cycles++;
            tick();
        end
        check("t1_busy_cycles", 32'(busy_cycles), 32'd9);
        check("t1_pkts", 32'(pkts), 32'd1);
        check("t1_overflow", 32'(overflow), 32'd0);

        // Normal mode, 4 samples on every other cycle
        for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), 16'h00A0 + 16'(i)});
        start(32'd4, 1'b0);
        for (int i = 0; i < 8; i++) begin
            adc_valid = (i % 2 == 0);
            adc_data  = 16'h00A0 + 16'(i / 2);
            tick();
        end
        adc_valid = 1'b0;
        wait_pkts(2, 50);
        check("t2_overflow", 32'(overflow), 32'd0);

        // Overflow: 16 accepted, drops while full, resume one cycle after the first pop
        for (int k = 0; k < 40; k++) begin
            if (k < 16) exp_q.push_back({1'b0, 16'h0100 + 16'(k)});
            else        exp_q.push_back({(k == 39), 16'h010F + 16'(k)});
        end
        start(32'd40, 1'b0);
        for (int i = 0; i < 55; i++) begin
            adc_valid   = 1'b1;
            adc_data    = 16'h0100 + 16'(i);
            axis.TREADY = (i >= 30);
            tick();
        end
        adc_valid   = 1'b0;
        axis.TREADY = 1'b1;
        wait_pkts(3, 100);
        check("t3_overflow", 32'(overflow), 32'd1);

        // dsize=0 start is ignored and leaves overflow sticky
        start(32'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("t4_busy", 32'(busy), 32'd0);
            tick();
        end
        check("t4_overflow_sticky", 32'(overflow), 32'd1);
        check("t4_pkts", 32'(pkts), 32'd3);

        // Back-pressure with random TREADY
        push_pattern(20);
        start(32'd20, 1'b1);
        check("t5_overflow_cleared", 32'(overflow), 32'd0);
        c = 0;
        while (pkts < 4 && c < 500) begin
            axis.TREADY = 1'($urandom_range(0, 1));
            tick();
            c++;
        end
        axis.TREADY = 1'b1;
        wait_pkts(4, 50);
        tick();

        // Second start during CAPTURE is ignored
        push_pattern(6);
        start(32'd6, 1'b1);
        tick();
        cr_start = 1'b1;
        dsize    = 32'd3;
        cr_test  = 1'b0;
        tick();
        cr_start = 1'b0;
        wait_pkts(5, 50);
        for (int i = 0; i < 20; i++) tick();
        check("t6_no_extra_pkt", 32'(pkts), 32'd5);
        check("t6_busy", 32'(busy), 32'd0);

        // Reset mid-capture after 3 beats, then a clean packet
        push_pattern(10);
        b0 = beats;
        p0 = pkts;
        start(32'd10, 1'b1);
        c = 0;
        while (beats < b0 + 3 && c < 50) begin
            tick();
            c++;
        end
        check("t7_three_beats", 32'(beats - b0), 32'd3);
        ARESETN = 1'b0;
        #1;
        check("t7_rst_tvalid", 32'(axis.TVALID), 32'd0);
        check("t7_rst_busy", 32'(busy), 32'd0);
        check("t7_rst_overflow", 32'(overflow), 32'd0);
        check("t7_rst_tlast", 32'(axis.TLAST), 32'd0);
        exp_q.delete();
        tick();
        tick();
        ARESETN = 1'b1;
        tick();
        check("t7_no_partial_pkt", 32'(pkts), 32'(p0));
        push_pattern(10);
        start(32'd10, 1'b1);
        wait_pkts(p0 + 1, 60);
        tick();
        tick();

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("total_pkts", 32'(pkts), 32'd6);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
